muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 18 +
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM state type and default operand width.
package muldiv_unit_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MULHU = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_REMU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage : muldiv_unit_pkg

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface muldiv_unit_if
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) ();

   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic            kill;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic            div_zero;

   modport master (
      output start, op, in_a, in_b, kill,
      input  busy, done, result, div_zero
   );

   modport slave (
      input  start, op, in_a, in_b, kill,
      output busy, done, result, div_zero
   );

endinterface : muldiv_unit_if

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (radix-2 shift-add) and restoring divide,
// one bit per cycle, sharing a single 2*XLEN accumulator and counter.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int ITER = XLEN
) (
   input  logic          clk,
   input  logic          rst_n,
   muldiv_unit_if.slave  bus
);

   localparam int             CW       = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0]  LAST_CNT = CW'(ITER - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   state_e            state_r;
   logic [1:0]        op_r;
   logic [XLEN-1:0]   a_r;
   logic [XLEN-1:0]   b_r;
   logic [2*XLEN-1:0] acc_r;
   logic [CW-1:0]     cnt_r;
   logic              busy_r;
   logic              done_r;
   logic              div_zero_r;
   logic [XLEN-1:0]   result_r;

   logic [XLEN:0]     mul_sum_s;
   logic [2*XLEN-1:0] mul_next_s;
   logic [CW-1:0]     div_idx_s;
   logic [XLEN:0]     div_trial_s;
   logic [XLEN-1:0]   div_diff_s;
   logic [2*XLEN-1:0] div_next_s;
   logic [2*XLEN-1:0] acc_next_s;
   logic [XLEN-1:0]   result_next_s;

   // Next accumulator value for one multiply or divide step, and the result it yields.
   always_comb begin
      mul_sum_s     = {1'b0, acc_r[2*XLEN-1:XLEN]};
      mul_next_s    = {2*XLEN{1'b0}};
      div_idx_s     = LAST_CNT - cnt_r;
      div_trial_s   = {acc_r[2*XLEN-1:XLEN], a_r[div_idx_s]};
      div_diff_s    = div_trial_s[XLEN-1:0] - b_r;
      div_next_s    = {2*XLEN{1'b0}};
      acc_next_s    = {2*XLEN{1'b0}};
      result_next_s = {XLEN{1'b0}};

      // Multiplier bits are consumed LSB first; the product shifts right into the low half.
      if (b_r[cnt_r]) begin
         mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, a_r};
      end else begin
         mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
      end
      mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};

      // Partial remainder lives in the high half, quotient bits shift into the low half.
      if (div_trial_s >= {1'b0, b_r}) begin
         div_next_s = {div_diff_s, acc_r[XLEN-2:0], 1'b1};
      end else begin
         div_next_s = {div_trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end

      if (op_r[1]) begin
         acc_next_s = div_next_s;
      end else begin
         acc_next_s = mul_next_s;
      end

      case (op_r)
         OP_MUL:   result_next_s = acc_next_s[XLEN-1:0];
         OP_MULHU: result_next_s = acc_next_s[2*XLEN-1:XLEN];
         OP_DIVU:  result_next_s = acc_next_s[XLEN-1:0];
         OP_REMU:  result_next_s = acc_next_s[2*XLEN-1:XLEN];
         default:  result_next_s = {XLEN{1'b0}};
      endcase
   end

   // Control FSM, operand latches, accumulator and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         op_r       <= OP_MUL;
         a_r        <= {XLEN{1'b0}};
         b_r        <= {XLEN{1'b0}};
         acc_r      <= {2*XLEN{1'b0}};
         cnt_r      <= {CW{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
         result_r   <= {XLEN{1'b0}};
      end else begin
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  op_r   <= bus.op;
                  a_r    <= bus.in_a;
                  b_r    <= bus.in_b;
                  acc_r  <= {2*XLEN{1'b0}};
                  cnt_r  <= {CW{1'b0}};
                  busy_r <= 1'b1;
                  // Divide by zero skips iteration: DIVU gives all ones, REMU gives the dividend.
                  if (bus.op[1] && (bus.in_b == {XLEN{1'b0}})) begin
                     state_r    <= ST_DONE;
                     done_r     <= 1'b1;
                     div_zero_r <= 1'b1;
                     result_r   <= bus.op[0] ? bus.in_a : {XLEN{1'b1}};
                  end else begin
                     state_r <= ST_RUN;
                  end
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (bus.kill) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  acc_r <= acc_next_s;
                  cnt_r <= cnt_r + CNT_ONE;
                  if (cnt_r == LAST_CNT) begin
                     state_r  <= ST_DONE;
                     done_r   <= 1'b1;
                     result_r <= result_next_s;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.div_zero = div_zero_r;
   assign bus.result   = result_r;

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results,
// divide-by-zero, kill, ignored start and asynchronous reset.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32), .ITER(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and check latency, result and trailing state.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_dz, input int exp_lat,
                        input logic with_kill, input string name);
      int edges;
      bus.start = 1'b1;
      bus.op    = op;
      bus.in_a  = a;
      bus.in_b  = b;
      bus.kill  = with_kill;
      step();
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      bus.in_a  = 32'hDEAD_BEEF;
      bus.in_b  = 32'h0BAD_F00D;
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL %s busy_after_start got=%b exp=1", name, bus.busy);
      end
      edges = 0;
      while (bus.done !== 1'b1 && edges < 40) begin
         step();
         edges++;
      end
      checks++;
      if (edges !== exp_lat) begin
         failures++;
         $display("FAIL %s latency got=%0d exp=%0d", name, edges, exp_lat);
      end
      checks++;
      if (bus.result !== exp_res) begin
         failures++;
         $display("FAIL %s result got=%h exp=%h", name, bus.result, exp_res);
      end
      checks++;
      if (bus.div_zero !== exp_dz) begin
         failures++;
         $display("FAIL %s div_zero got=%b exp=%b", name, bus.div_zero, exp_dz);
      end
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.div_zero !== 1'b0 || bus.result !== exp_res) begin
         failures++;
         $display("FAIL %s after_done got=%b%b%b/%h exp=000/%h", name, bus.done, bus.busy,
                  bus.div_zero, bus.result, exp_res);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = OP_MUL;
      bus.in_a  = 32'h0;
      bus.in_b  = 32'h0;
      bus.kill  = 1'b0;
      #23;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.result !== 32'h0) begin
         failures++;
         $display("FAIL reset got=%b%b%b/%h exp=000/00000000", bus.busy, bus.done, bus.div_zero, bus.result);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_mul();
      do_op(OP_MUL,   32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0, 32, 1'b0, "mul_7x6");
      do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32, 1'b0, "mulhu_max");
      do_op(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32, 1'b0, "mul_max");
      do_op(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 32, 1'b0, "mulhu_2p32");
      do_op(OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 32, 1'b0, "mul_2p32");
   endtask

   task automatic test_div();
      do_op(OP_DIVU, 32'd100,       32'd7,  32'd14,        1'b0, 32, 1'b0, "divu_100_7");
      do_op(OP_REMU, 32'd100,       32'd7,  32'd2,         1'b0, 32, 1'b0, "remu_100_7");
      do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1,  32'hFFFF_FFFF, 1'b0, 32, 1'b0, "divu_max_1");
      do_op(OP_REMU, 32'd5,         32'd10, 32'd5,         1'b0, 32, 1'b0, "remu_5_10");
      do_op(OP_DIVU, 32'd5,         32'd10, 32'd0,         1'b0, 32, 1'b0, "divu_5_10");
   endtask

   task automatic test_div_zero();
      do_op(OP_DIVU, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, "divu_by_0");
      do_op(OP_REMU, 32'h0000_1234, 32'h0, 32'h0000_1234, 1'b1, 0, 1'b0, "remu_by_0");
   endtask

   // Previous result is 0x1234 from the REMU-by-zero case.
   task automatic test_kill();
      int seen;
      bus.start = 1'b1;
      bus.op    = OP_MUL;
      bus.in_a  = 32'd3;
      bus.in_b  = 32'd5;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 9; i++) step();
      bus.kill = 1'b1;
      step();
      bus.kill = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL kill_busy got=%b exp=0", bus.busy);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) seen++;
         step();
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL kill_no_done got=%0d exp=0", seen);
      end
      checks++;
      if (bus.result !== 32'h0000_1234) begin
         failures++;
         $display("FAIL kill_result_hold got=%h exp=00001234", bus.result);
      end
      // Kill in IDLE with start: start must win.
      do_op(OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 32, 1'b1, "start_over_kill");
   endtask

   task automatic test_start_ignored();
      int edges;
      bus.start = 1'b1;
      bus.op    = OP_MUL;
      bus.in_a  = 32'h0000_0007;
      bus.in_b  = 32'h0000_0006;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.in_a  = 32'd100;
      bus.in_b  = 32'd0;
      step();
      bus.start = 1'b0;
      edges = 5;
      while (bus.done !== 1'b1 && edges < 40) begin
         step();
         edges++;
      end
      checks++;
      if (edges !== 32 || bus.result !== 32'h0000_002A || bus.div_zero !== 1'b0) begin
         failures++;
         $display("FAIL start_ignored got=%0d/%h/%b exp=32/0000002a/0", edges, bus.result, bus.div_zero);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int seen;
      bus.start = 1'b1;
      bus.op    = OP_MULHU;
      bus.in_a  = 32'hFFFF_FFFF;
      bus.in_b  = 32'hFFFF_FFFF;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.result !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid got=%b%b%b/%h exp=000/00000000", bus.busy, bus.done, bus.div_zero, bus.result);
      end
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
         step();
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL reset_mid_no_done got=%0d exp=0", seen);
      end
      do_op(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 32, 1'b0, "after_reset");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_kill();
      test_start_ignored();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_muldiv_unit
